adder_seq_ctrl: RTL and testbench

- Multi-precision add/subtract sequencer. It drives the team's combinational 4-bit ripple-carry adder one nibble per clock, least-significant nibble first.
- The adder's carry-out is chained into the carry-in of the next nibble, giving WIDTH-bit results from the single 4-bit adder.
- The adder instance sits outside this block. This block owns its a/b/cin inputs and samples its sum/cout outputs.

---
 rtl/adder_seq_ctrl.sv | 119 +++++++++++
 tb/tb_adder_seq_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: drives an external 4-bit ripple adder
// one nibble per clock, LSB nibble first, chaining carry between nibbles.
module adder_seq_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             op_sub_i,
    input  logic [WIDTH-1:0] a_in_i,
    input  logic [WIDTH-1:0] b_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_out_o,
    output logic             overflow_o,
    output logic [3:0]       add_a_o,
    output logic [3:0]       add_b_o,
    output logic             add_cin_o,
    input  logic [3:0]       add_sum_i,
    input  logic             add_cout_i
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             busy_q;
    logic             done_q;
    logic             last_nib;

    assign last_nib = (cnt_q == LAST_NIB);

    // Adder operands are presented only while sequencing nibbles.
    always_comb begin
        add_a_o   = 4'd0;
        add_b_o   = 4'd0;
        add_cin_o = 1'b0;
        if (state_q == S_RUN) begin
            add_a_o   = a_sh_q[3:0];
            add_b_o   = b_sh_q[3:0];
            add_cin_o = carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        // Subtract as a + ~b + 1; the +1 enters as the first carry-in.
                        a_sh_q  <= a_in_i;
                        b_sh_q  <= op_sub_i ? ~b_in_i : b_in_i;
                        carry_q <= op_sub_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_q <= WIDTH'({add_sum_i, result_q} >> 4);
                    carry_q  <= add_cout_i;
                    a_sh_q   <= a_sh_q >> 4;
                    b_sh_q   <= b_sh_q >> 4;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_nib) begin
                        carry_out_q <= add_cout_i;
                        overflow_q  <= (add_a_o[3] == add_b_o[3]) && (add_sum_i[3] != add_a_o[3]);
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign carry_out_o = carry_out_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl with a behavioural 4-bit adder on the nibble port.
module tb_adder_seq_ctrl;

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, op_sub;
    logic [15:0] a_in, b_in;
    logic        busy, done, carry_out, overflow;
    logic [15:0] result;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    logic        start4, op_sub4;
    logic [3:0]  a_in4, b_in4, result4, add_a4, add_b4, add_sum4;
    logic        busy4, done4, carry_out4, overflow4, add_cin4, add_cout4;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    // External ripple adders for both builds.
    assign {add_cout, add_sum}   = 5'(add_a) + 5'(add_b) + 5'(add_cin);
    assign {add_cout4, add_sum4} = 5'(add_a4) + 5'(add_b4) + 5'(add_cin4);

    adder_seq_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start_i(start), .op_sub_i(op_sub),
        .a_in_i(a_in), .b_in_i(b_in), .busy_o(busy), .done_o(done),
        .result_o(result), .carry_out_o(carry_out), .overflow_o(overflow),
        .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin),
        .add_sum_i(add_sum), .add_cout_i(add_cout)
    );

    adder_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start_i(start4), .op_sub_i(op_sub4),
        .a_in_i(a_in4), .b_in_i(b_in4), .busy_o(busy4), .done_o(done4),
        .result_o(result4), .carry_out_o(carry_out4), .overflow_o(overflow4),
        .add_a_o(add_a4), .add_b_o(add_b4), .add_cin_o(add_cin4),
        .add_sum_i(add_sum4), .add_cout_i(add_cout4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic c, input logic v);
        exp_t e;
        e.r = r; e.c = c; e.v = v;
        return e;
    endfunction

    function automatic exp_t ref16(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic [16:0] s;
        exp_t e;
        s = sub ? (17'(a) - 17'(b) + 17'h10000) : (17'(a) + 17'(b));
        e.r = s[15:0];
        e.c = s[16];
        e.v = sub ? ((a[15] != b[15]) && (s[15] != a[15])) : ((a[15] == b[15]) && (s[15] != a[15]));
        return e;
    endfunction

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.r));
                check("carry_out", 32'(carry_out), 32'(e.c));
                check("overflow", 32'(overflow), 32'(e.v));
            end
            if (prev_done) check("done_one_cycle", 32'd1, 32'd0);
        end
        prev_done = done;
    end

    // Issue one operation from IDLE at a negedge; returns at a negedge back in IDLE.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input exp_t e, output logic [3:0] cin_seq);
        int  nb;
        bit  seen;
        nb = 0;
        seen = 0;
        cin_seq = 4'd0;
        sb.push_back(e);
        a_in = a; b_in = b; op_sub = sub; start = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) begin
                if (nb < 4) cin_seq[nb] = add_cin;
                nb++;
            end
            if (done) seen = 1;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_cycles", 32'(nb), 32'd4);
        @(negedge clk);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sub,
                       input logic [3:0] er, input logic ec, input logic ev);
        int nb;
        bit seen;
        nb = 0;
        seen = 0;
        a_in4 = a; b_in4 = b; op_sub4 = sub; start4 = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (busy4) nb++;
            if (done4) seen = 1;
        end
        check("w4_done_seen", 32'(seen), 32'd1);
        check("w4_busy_cycles", 32'(nb), 32'd1);
        check("w4_result", 32'(result4), 32'(er));
        check("w4_carry_out", 32'(carry_out4), 32'(ec));
        check("w4_overflow", 32'(overflow4), 32'(ev));
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  cin_seq;
        logic [15:0] ra, rb;
        logic        rs;
        int          nb;
        bit          seen;

        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a_in = '0; b_in = '0;
        start4 = 1'b0; op_sub4 = 1'b0; a_in4 = '0; b_in4 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_add_ab", 32'({add_a, add_b, add_cin}), 32'd0);
        @(negedge clk);

        do_op(16'h00FF, 16'h0001, 1'b0, mk(16'h0100, 1'b0, 1'b0), cin_seq);
        check("cin_sequence", 32'(cin_seq), 32'(4'b0110));
        check("idle_add_ab", 32'({add_a, add_b, add_cin}), 32'd0);
        do_op(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0), cin_seq);
        do_op(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1), cin_seq);
        do_op(16'h1234, 16'h0235, 1'b1, mk(16'h0FFF, 1'b1, 1'b0), cin_seq);
        check("sub_first_cin", 32'(cin_seq[0]), 32'd1);
        do_op(16'h0000, 16'h0001, 1'b1, mk(16'hFFFF, 1'b0, 1'b0), cin_seq);
        do_op(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1), cin_seq);

        // start held high; operands change during RUN and must be ignored.
        sb.push_back(mk(16'h0003, 1'b0, 1'b0));
        sb.push_back(mk(16'h0030, 1'b0, 1'b0));
        a_in = 16'h0001; b_in = 16'h0002; op_sub = 1'b0; start = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else begin a_in = 16'(i * 16'h1111); b_in = 16'hABCD; op_sub = 1'b1; end
        end
        check("hold_done_seen", 32'(seen), 32'd1);
        a_in = 16'h0010; b_in = 16'h0020; op_sub = 1'b0;
        @(negedge clk);
        check("hold_idle_gap", 32'(busy), 32'd0);
        @(negedge clk);
        check("hold_restart", 32'(busy), 32'd1);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("hold_second_done", 32'(seen), 32'd1);
        @(negedge clk);

        // Reset during the second RUN cycle aborts with no done pulse.
        a_in = 16'h1111; b_in = 16'h2222; op_sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_run1", 32'(busy), 32'd1);
        @(negedge clk);
        check("abort_run2", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'({carry_out, overflow}), 32'd0);
        check("abort_add_ab", 32'({add_a, add_b, add_cin}), 32'd0);
        repeat (6) @(negedge clk);
        do_op(16'h0003, 16'h0005, 1'b0, mk(16'h0008, 1'b0, 1'b0), cin_seq);

        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            do_op(ra, rb, rs, ref16(ra, rb, rs), cin_seq);
        end

        op4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
        op4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
        op4(4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0);
        op4(4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1);

        repeat (4) @(negedge clk);
        nb = sb.size();
        check("scoreboard_drained", 32'(nb), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
